// File: rtl/lc4_muldiv_pkg.sv
// rtl/lc4_muldiv_pkg.sv - op encodings and FSM states for the LC4 multiply/divide unit
package lc4_muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // True for the two ops that run through the restoring divider
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/lc4_divstep.sv
// rtl/lc4_divstep.sv - one combinational restoring-division step
module lc4_divstep #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // Shift in the next dividend bit, trial-subtract, keep or restore the remainder
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[W];
    rem_next = diff[W] ? shifted[W-1:0] : diff[W-1:0];
  end

endmodule

// File: rtl/lc4_muldiv.sv
// rtl/lc4_muldiv.sv - iterative unsigned MUL/DIV/MOD unit with valid/ack handshake
module lc4_muldiv
  import lc4_muldiv_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic [WORD_SIZE-1:0] i_r1data,
  input  logic [WORD_SIZE-1:0] i_r2data,
  input  logic                 i_ack,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [WORD_SIZE-1:0] o_result
);

  localparam int CW = $clog2(WORD_SIZE) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WORD_SIZE - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [1:0]           op_q;
  // a_q: multiplicand (shifts left) or dividend shifting out / quotient shifting in
  // b_q: multiplier (shifts right) or fixed divisor
  // acc_q: product accumulator or partial remainder
  logic [WORD_SIZE-1:0] a_q;
  logic [WORD_SIZE-1:0] b_q;
  logic [WORD_SIZE-1:0] acc_q;
  logic                 valid_q;
  logic [WORD_SIZE-1:0] result_q;

  logic [WORD_SIZE-1:0] rem_next;
  logic                 q_bit;
  logic [WORD_SIZE-1:0] final_result;

  lc4_divstep #(.W(WORD_SIZE)) u_divstep (
    .rem          (acc_q),
    .dividend_bit (a_q[WORD_SIZE-1]),
    .divisor      (b_q),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  // Pick the finished value out of the shared datapath registers by op
  always_comb begin
    final_result = '0;
    case (op_q)
      OP_MUL:  final_result = acc_q;
      OP_DIV:  final_result = a_q;
      OP_MOD:  final_result = acc_q;
      default: final_result = '0;
    endcase
  end

  // Control FSM and datapath; o_valid/o_result are registered one cycle after DONE entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            op_q  <= i_op;
            cnt   <= '0;
            acc_q <= '0;
            if ((i_op == OP_MUL) || (op_is_div(i_op) && (i_r2data != '0))) begin
              a_q   <= i_r1data;
              b_q   <= i_r2data;
              state <= ST_RUN;
            end else begin
              // Divide by zero and the reserved op short-circuit to a zero result
              a_q   <= '0;
              b_q   <= '0;
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (op_q == OP_MUL) begin
            if (b_q[0]) begin
              acc_q <= acc_q + a_q;
            end
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end else begin
            acc_q <= rem_next;
            a_q   <= {a_q[WORD_SIZE-2:0], q_bit};
          end
          if (cnt == LAST_ITER) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!valid_q) begin
            valid_q  <= 1'b1;
            result_q <= final_result;
          end else if (i_ack) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = (state != ST_IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_lc4_muldiv.sv
// tb/tb_lc4_muldiv.sv - self-checking bench for lc4_muldiv
module tb_lc4_muldiv;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_op;
  logic [15:0] i_r1data;
  logic [15:0] i_r2data;
  logic        i_ack;
  logic        o_busy;
  logic        o_valid;
  logic [15:0] o_result;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  lc4_muldiv #(.WORD_SIZE(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_r1data (i_r1data),
    .i_r2data (i_r2data),
    .i_ack    (i_ack),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic from the operation definitions
  function automatic logic [15:0] model_res(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned p;
    case (op)
      2'b00: begin
        p = 32'(a) * 32'(b);
        return p[15:0];
      end
      2'b01: return (b == 0) ? 16'h0 : a / b;
      2'b10: return (b == 0) ? 16'h0 : a % b;
      default: return 16'h0;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [15:0] b);
    if (op == 2'b11) return 1;
    if (op != 2'b00 && b == 0) return 1;
    return 17;
  endfunction

  task automatic start_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    i_op     = op;
    i_r1data = a;
    i_r2data = b;
    i_start  = 1'b1;
    @(posedge clk);
    #1;
    i_start  = 1'b0;
    i_r1data = $urandom;
    i_r2data = $urandom;
  endtask

  // Counts edges since the accepting edge until o_valid; lat=0 means it never came
  task automatic wait_valid(input int already, output int lat, output logic zero_ok);
    lat = 0;
    zero_ok = 1'b1;
    for (int k = already + 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = k;
        break;
      end
      if (o_result !== 16'h0) zero_ok = 1'b0;
    end
  endtask

  task automatic ack_result(input string name);
    i_ack = 1'b1;
    @(posedge clk);
    #1;
    i_ack = 1'b0;
    chk({name, " busy after ack"}, {31'b0, o_busy}, 32'd0);
    chk({name, " valid after ack"}, {31'b0, o_valid}, 32'd0);
  endtask

  task automatic run_one(input string name, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_res, input int exp_lat);
    int   lat;
    logic zero_ok;
    start_req(op, a, b);
    wait_valid(0, lat, zero_ok);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " result"}, {16'b0, o_result}, {16'b0, exp_res});
    chk({name, " result zero before valid"}, {31'b0, zero_ok}, 32'd1);
    ack_result(name);
  endtask

  initial begin
    int          lat;
    logic        zero_ok;
    logic        stable;
    logic [1:0]  rop;
    logic [15:0] ra, rb;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_op     = 2'b00;
    i_r1data = 16'h0;
    i_r2data = 16'h0;
    i_ack    = 1'b0;

    vecs[0]  = '{2'b00, 16'd7,    16'd6,    16'h002A, 17};
    vecs[1]  = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 17};
    vecs[2]  = '{2'b01, 16'd100,  16'd7,    16'h000E, 17};
    vecs[3]  = '{2'b10, 16'd100,  16'd7,    16'h0002, 17};
    vecs[4]  = '{2'b01, 16'h1234, 16'h0000, 16'h0000, 1};
    vecs[5]  = '{2'b10, 16'd5,    16'h0000, 16'h0000, 1};
    vecs[6]  = '{2'b11, 16'd50,   16'd3,    16'h0000, 1};
    vecs[7]  = '{2'b01, 16'd5,    16'd9,    16'h0000, 17};
    vecs[8]  = '{2'b10, 16'd5,    16'd9,    16'h0005, 17};
    vecs[9]  = '{2'b01, 16'hFFFF, 16'h0001, 16'hFFFF, 17};
    vecs[10] = '{2'b00, 16'h8000, 16'h0002, 16'h0000, 17};
    vecs[11] = '{2'b00, 16'h0100, 16'h0101, 16'h0100, 17};
    vecs[12] = '{2'b10, 16'hFFFF, 16'h0100, 16'h00FF, 17};
    vecs[13] = '{2'b01, 16'hFFFF, 16'hFFFF, 16'h0001, 17};

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, o_busy}, 32'd0);
    chk("reset valid", {31'b0, o_valid}, 32'd0);
    chk("reset result", {16'b0, o_result}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run_one($sformatf("rand%0d op=%0d a=%0h b=%0h", i, rop, ra, rb), rop, ra, rb,
              model_res(rop, ra, rb), model_lat(rop, rb));
    end

    // Second request pulsed mid-RUN must be dropped
    start_req(2'b00, 16'd7, 16'd6);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start_req(2'b01, 16'd100, 16'd7);
    wait_valid(4, lat, zero_ok);
    chk("start during run latency", lat, 17);
    chk("start during run result", {16'b0, o_result}, 32'h2A);
    ack_result("start during run");
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("second request not executed", {30'b0, o_busy, o_valid}, 32'd0);

    // i_ack during RUN is ignored; held-off ack keeps result stable
    start_req(2'b10, 16'd100, 16'd7);
    i_ack = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    i_ack = 1'b0;
    wait_valid(3, lat, zero_ok);
    chk("ack during run latency", lat, 17);
    chk("ack during run result", {16'b0, o_result}, 32'h2);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (o_valid !== 1'b1 || o_result !== 16'h0002 || o_busy !== 1'b1) stable = 1'b0;
    end
    chk("hold without ack stable", {31'b0, stable}, 32'd1);
    ack_result("hold without ack");

    // Reset in RUN aborts, then a fresh MUL works
    start_req(2'b00, 16'd200, 16'd300);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset in run outputs", {15'b0, o_busy, o_valid, o_result}, 32'd0);
    run_one("mul after reset", 2'b00, 16'd3, 16'd5, 16'h000F, 17);

    // Reset in DONE with i_start held: abort, no accept
    start_req(2'b00, 16'd9, 16'd9);
    wait_valid(0, lat, zero_ok);
    chk("pre-reset done result", {16'b0, o_result}, 32'd81);
    rst_n    = 1'b0;
    i_start  = 1'b1;
    i_op     = 2'b00;
    i_r1data = 16'd2;
    i_r2data = 16'd2;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    i_start = 1'b0;
    chk("reset in done outputs", {15'b0, o_busy, o_valid, o_result}, 32'd0);
    @(posedge clk);
    #1;
    chk("start during reset ignored", {31'b0, o_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc4_muldiv.md
LC4_MULDIV -- requirements
Module: lc4_muldiv

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set the operand and result width.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the reset: synchronous and active-low.
REQ-004 Port i_start, input, 1, SHALL be the request strobe from the ALU for MUL/DIV/MOD.
REQ-005 Port i_op, input, 2, SHALL select the operation: 00 MUL, 01 DIV, 10 MOD; 11 is reserved.
REQ-006 Port i_r1data, input, WORD_SIZE, SHALL carry operand A (multiplicand / dividend).
REQ-007 Port i_r2data, input, WORD_SIZE, SHALL carry operand B (multiplier / divisor).
REQ-008 Port i_ack, input, 1, SHALL be the consumer acknowledge of a presented result.
REQ-009 Port o_busy, output, 1, SHALL be high whenever the state is not IDLE.
REQ-010 Port o_valid, output, 1, SHALL be high when o_result holds a finished result.
REQ-011 Port o_result, output, WORD_SIZE, SHALL be the result.

Function
REQ-012 The block SHALL use states IDLE, RUN and DONE only.
REQ-013 In IDLE with i_start=1, the block SHALL latch i_op, A and B and enter RUN with the iteration counter at 0.
REQ-014 i_start SHALL be ignored in RUN and DONE; latched operands SHALL NOT change in those states.
REQ-015 MUL SHALL be unsigned radix-2 shift-add over WORD_SIZE iterations, keeping the low WORD_SIZE bits of the product.
REQ-016 DIV and MOD SHALL be unsigned restoring division over WORD_SIZE iterations; DIV returns the quotient, MOD the remainder.
REQ-017 Each RUN cycle SHALL perform one iteration; after the counter reaches WORD_SIZE-1, the next edge SHALL enter DONE.
REQ-018 o_valid SHALL rise exactly WORD_SIZE+1 edges after the accepting edge (17 for default).
REQ-019 DIV or MOD with B=0 SHALL skip RUN, enter DONE on the accepting edge+1, and set o_result=0.
REQ-020 i_op=11 SHALL behave like B=0 division: DONE after 1 cycle with o_result=0.
REQ-021 In DONE, o_valid=1 and o_result SHALL stay stable until i_ack=1, then the block returns to IDLE on that edge.
REQ-022 i_ack outside DONE SHALL be ignored.
REQ-023 A new request SHALL be accepted no earlier than the cycle after the return to IDLE (no accept in DONE).
REQ-024 o_result SHALL be 0 whenever o_valid=0.
REQ-025 The counter SHALL be log2(WORD_SIZE)+1 bits wide and never wrap during a RUN.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL enter IDLE, clear the counter and all datapath registers, and drive o_busy=0, o_valid=0, o_result=0.
REQ-027 Reset in RUN or DONE SHALL abort the operation with no result presented; i_start in that cycle SHALL be ignored.

Structure
REQ-028 Package lc4_muldiv_pkg SHALL hold the op encodings (OP_MUL, OP_DIV, OP_MOD) and the state enumeration.
REQ-029 Sub-module lc4_divstep SHALL implement one combinational restoring-division step (shift remainder, trial subtract, quotient bit); lc4_muldiv instantiates it once.

Verification
REQ-030 MUL A=7, B=6 -> o_valid high 17 cycles after accept, o_result=0x002A; i_ack -> IDLE next cycle.
REQ-031 MUL A=0xFFFF, B=0xFFFF -> o_result=0x0001; DIV A=100, B=7 -> 0x000E; MOD A=100, B=7 -> 0x0002.
REQ-032 DIV A=0x1234, B=0 -> o_valid one cycle after accept, o_result=0x0000, o_busy low after i_ack.
REQ-033 i_start pulsed during RUN with different operands -> first result unchanged, second request not executed.
REQ-034 Hold i_ack=0 for 10 cycles after o_valid -> o_valid and o_result stable throughout.
REQ-035 rst_n=0 at RUN cycle 5 -> next cycle o_busy=0, o_valid=0, o_result=0; a following MUL 3*5 returns 0x000F after 17 cycles.
